// File: rtl/plot_pkg.sv
// Shared framebuffer geometry, FIFO entry layout and the xy to linear address mapping
// for the pixel plot path.
package plot_pkg;

  localparam int unsigned FB_W      = 160;
  localparam int unsigned FB_H      = 120;
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned COLOUR_W  = 3;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0]  colour;
  } plot_entry_t;

  // The default 160-wide screen uses shift-add (128 + 32) instead of a multiplier.
  function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                      input logic [6:0] y,
                                                      input int unsigned w);
    logic [FB_ADDR_W-1:0] a;
    if (w == 32'd160) begin
      a = FB_ADDR_W'({y, 7'b0}) + FB_ADDR_W'({y, 5'b0}) + FB_ADDR_W'(x);
    end else begin
      a = FB_ADDR_W'(32'(y) * w + 32'(x));
    end
    return a;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries. A push is accepted when the FIFO is full only if
// a pop happens in the same cycle, so the count stays unchanged.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  plot_entry_t              wdata_i,
  output plot_entry_t              head_c_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  plot_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          pop_ok_c, push_ok_c;

  always_comb begin
    pop_ok_c  = pop_i & ~empty_q;
    push_ok_c = push_i & (~full_q | pop_ok_c);
    wr_ptr_d  = push_ok_c ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_c  ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d   = CW'(count_q + CW'(push_ok_c) - CW'(pop_ok_c));
    full_d    = (count_d == CW'(DEPTH));
    empty_d   = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

endmodule

// File: rtl/plot_fifo_writer.sv
// Clips drawer pixels to the screen, buffers them and writes them to the framebuffer
// when granted. Define PLOT_CLIP_COUNT_EN to add the saturating clip_count output.
module plot_fifo_writer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FB_W  = plot_pkg::FB_W,
  parameter int unsigned FB_H  = plot_pkg::FB_H
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     in_x,
  input  logic [6:0]                     in_y,
  input  logic [plot_pkg::COLOUR_W-1:0]  in_colour,
  input  logic                           in_plot,
  input  logic                           fb_grant,
  input  logic                           clr_flags,
`ifdef PLOT_CLIP_COUNT_EN
  output logic [15:0]                    clip_count,
`endif
  output logic [plot_pkg::FB_ADDR_W-1:0] fb_addr,
  output logic [plot_pkg::COLOUR_W-1:0]  fb_wdata,
  output logic                           fb_we,
  output logic                           busy,
  output logic                           overflow
);

  import plot_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  plot_entry_t          new_entry_c, head_c;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count, cnt_next_c;
  logic                 in_range_c, push_c, pop_c, drop_c;

  logic                 fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]  fb_wdata_q, fb_wdata_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  always_comb begin
    in_range_c         = (32'(in_x) < FB_W) && (32'(in_y) < FB_H);
    pop_c              = ~fifo_empty & fb_grant;
    push_c             = in_plot & in_range_c & (~fifo_full | pop_c);
    drop_c             = in_plot & in_range_c & fifo_full & ~pop_c;
    new_entry_c.addr   = xy_to_addr(in_x, in_y, FB_W);
    new_entry_c.colour = in_colour;
    cnt_next_c         = CW'(fifo_count + CW'(push_c) - CW'(pop_c));
  end

  plot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .wdata_i  (new_entry_c),
    .head_c_o (head_c),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Write stage and flags; busy is registered from the next-cycle count and strobe.
  always_comb begin
    fb_we_d    = pop_c;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (pop_c) begin
      fb_addr_d  = head_c.addr;
      fb_wdata_d = head_c.colour;
    end
    busy_d     = pop_c | (cnt_next_c != '0);
    overflow_d = overflow_q;
    if (drop_c)         overflow_d = 1'b1;
    else if (clr_flags) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PLOT_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic        clip_c;

  // A clip coinciding with a clear counts as the first clip after the clear.
  always_comb begin
    clip_c     = in_plot & ~in_range_c;
    clip_cnt_d = clip_cnt_q;
    if (clr_flags)                          clip_cnt_d = clip_c ? 16'd1 : 16'd0;
    else if (clip_c && clip_cnt_q != 16'hFFFF) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_cnt_q <= '0;
    else     clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`endif

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_plot_fifo_writer.sv
// Directed bench for plot_fifo_writer: latency, clipping, overflow, full push+pop,
// mid-stream reset and flag clearing against hand-computed values.
module tb_plot_fifo_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [2:0]  in_colour = '0;
  logic        in_plot = 1'b0;
  logic        fb_grant = 1'b0;
  logic        clr_flags = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        busy;
  logic        overflow;
`ifdef PLOT_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] wlog[$];

  plot_fifo_writer #(.DEPTH(16), .FB_W(160), .FB_H(120)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_colour (in_colour),
    .in_plot   (in_plot),
    .fb_grant  (fb_grant),
    .clr_flags (clr_flags),
`ifdef PLOT_CLIP_COUNT_EN
    .clip_count(clip_count),
`endif
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_we     (fb_we),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && fb_we) wlog.push_back({fb_addr, fb_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
    in_plot   = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] ent(input int x, input int y, input int c);
    return 32'({15'(y * 160 + x), 3'(c)});
  endfunction

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_we",    32'(fb_we), 32'd0);
    chk("rst_addr",  32'(fb_addr), 32'd0);
    chk("rst_wdata", 32'(fb_wdata), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single pixel latency with grant held high
    fb_grant = 1'b1;
    plot(10, 5, 3);
    in_plot = 1'b0;
    chk("lat_we_n1",   32'(fb_we), 32'd0);
    chk("lat_busy_n1", 32'(busy), 32'd1);
    tick();
    chk("lat_we_n2",   32'(fb_we), 32'd1);
    chk("lat_addr",    32'(fb_addr), 32'd810);
    chk("lat_wdata",   32'(fb_wdata), 32'd3);
    tick();
    chk("lat_we_done", 32'(fb_we), 32'd0);
    chk("lat_busy_0",  32'(busy), 32'd0);
    chk("lat_hold",    32'(fb_addr), 32'd810);

    // Clipping at the screen edges
    wlog.delete();
    plot(159, 119, 5);
    plot(160, 0, 1);
    plot(0, 120, 2);
    in_plot = 1'b0;
    repeat (4) tick();
    chk("clip_nwr", 32'(wlog.size()), 32'd1);
    chk("clip_wr0", 32'(wlog[0]), 32'({15'd19199, 3'd5}));
`ifdef PLOT_CLIP_COUNT_EN
    chk("clip_cnt", 32'(clip_count), 32'd2);
`endif

    // Overflow: 20 plots with no grant, first 16 kept in order
    wlog.delete();
    fb_grant = 1'b0;
    for (int i = 0; i < 20; i++) plot(i, 1, i);
    in_plot = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_nowe", 32'(fb_we), 32'd0);
    fb_grant = 1'b1;
    repeat (20) tick();
    chk("ovf_nwr", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_wr%0d", i), 32'(wlog[i]), ent(i, 1, i));
    chk("ovf_idle", 32'(busy), 32'd0);

    // clr_flags alone, then clr coincident with a drop
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);
    fb_grant = 1'b0;
    for (int i = 0; i < 16; i++) plot(i, 2, i);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    plot(16, 2, 0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    clr_flags = 1'b1;
    plot(17, 2, 0);
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    in_plot = 1'b0;
    tick();
    clr_flags = 1'b0;
    chk("clr_next", 32'(overflow), 32'd0);
    fb_grant = 1'b1;
    repeat (20) tick();
    wlog.delete();

    // Push while full with a simultaneous pop
    fb_grant = 1'b0;
    for (int i = 0; i < 16; i++) plot(i, 3, i);
    fb_grant = 1'b1;
    plot(16, 3, 16);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_we",  32'(fb_we), 32'd1);
    fb_grant = 1'b0;
    plot(17, 3, 17);
    chk("fpp_still_full", 32'(overflow), 32'd1);
    in_plot  = 1'b0;
    fb_grant = 1'b1;
    repeat (20) tick();
    chk("fpp_nwr", 32'(wlog.size()), 32'd17);
    for (int i = 0; i < 17; i++) chk($sformatf("fpp_wr%0d", i), 32'(wlog[i]), ent(i, 3, i));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Reset with 8 pixels buffered and a write in flight
    fb_grant = 1'b0;
    for (int i = 0; i < 8; i++) plot(i, 4, i);
    in_plot  = 1'b0;
    fb_grant = 1'b1;
    tick();
    chk("mid_we_pre", 32'(fb_we), 32'd1);
    wlog.delete();
    rst = 1'b1;
    #1;
    chk("mid_we_async", 32'(fb_we), 32'd0);
    chk("mid_busy_async", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_nwr",  32'(wlog.size()), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ovf",  32'(overflow), 32'd0);
    chk("mid_we",   32'(fb_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/plot_fifo_writer.md
# plot_fifo_writer

Downstream stage of the shape drawers (circle, Reuleaux, fill). It accepts the drawer's per-cycle pixel stream (x, y, colour, plot strobe), clips it to the 160×120 screen, and converts each pixel to a linear framebuffer address. It buffers accepted pixels in a small FIFO and writes them into the framebuffer RAM only in cycles where scan-out grants the shared write port. Drawers need no backpressure; overflow is flagged, never silent.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 4..64.
- FB_W, 160: screen width in pixels.
- FB_H, 120: screen height in pixels.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_x  in  8  pixel x from drawer.
- in_y  in  7  pixel y from drawer.
- in_colour  in  3  pixel colour.
- in_plot  in  1  pixel valid this cycle.
- fb_grant  in  1  framebuffer write port free this cycle.
- clr_flags  in  1  synchronous clear of overflow (and clip counter if compiled in).
- fb_addr  out  15  linear address y*FB_W+x.
- fb_wdata  out  3  colour to write.
- fb_we  out  1  write strobe, one cycle per pixel.
- busy  out  1  FIFO non-empty or write in flight.
- overflow  out  1  sticky: at least one in-range pixel dropped because FIFO was full.

## Operation
- Clip: pixel in range iff in_x < FB_W and in_y < FB_H. Out-of-range plots are discarded, never enqueued.
- Address: computed at enqueue as (y<<7)+(y<<5)+x for FB_W=160, generic y*FB_W+x otherwise; 15-bit result (max 19199). FIFO entry = {addr[14:0], colour[2:0]}, 18 bits.
- Push: in_plot & in-range & (not full or pop this cycle).
- Drop: in_plot & in-range & full & no pop → pixel lost, overflow←1.
- Pop: FIFO non-empty & fb_grant.
- Simultaneous push and pop when full: both happen, count unchanged, no overflow.
- Simultaneous push and pop when empty: new pixel not bypassed; it is popped no earlier than the next cycle.
- Order strictly preserved; no coalescing of repeated addresses.
- Write stage: on pop, fb_addr/fb_wdata load the head entry and fb_we=1 for the following cycle; otherwise fb_we=0 and fb_addr/fb_wdata hold their last value.
- clr_flags: overflow←0 next edge; a drop in the same cycle wins (overflow stays 1).
- busy = (count≠0) | fb_we.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers 0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, overflow=0, clip counter=0.
- Reset mid-stream flushes all buffered pixels; no write occurs after reset asserts.
- Latency: in_plot at cycle N with fb_grant high at N+1 → fb_we at N+2. Minimum 2 cycles, unbounded with grant low.
- Throughput: one accepted pixel per cycle; one write per granted cycle.
- fb_grant is sampled only when non-empty; grant with empty FIFO has no effect.

## Configuration
- PLOT_CLIP_COUNT_EN defined: adds output clip_count [15:0], a saturating count of out-of-range plots (holds at 16'hFFFF) cleared by clr_flags. When clr_flags and a clip coincide, the count becomes 1.
- Undefined: port and counter absent; clipping behaviour unchanged.

## Structure
- Package plot_pkg: FB_W, FB_H, FB_ADDR_W=15, COLOUR_W=3, packed struct plot_entry_t {addr, colour}, and a function for xy→addr.
- Sub-module plot_fifo: synchronous FIFO of plot_entry_t, parameter DEPTH, push/pop/full/empty/count, and defined behaviour for push+pop when full.
- Top holds the clip logic, address computation, write-stage registers and flags.

## Test plan
- Reset, then in_plot with (x=10, y=5, colour=3) at N and fb_grant held 1 → fb_we at N+2 with fb_addr=810, fb_wdata=3, then busy=0.
- Plots (159,119) and (160,0), then (0,120) → only addr 19199 written; with PLOT_CLIP_COUNT_EN, clip_count=2.
- fb_grant=0 for 20 cycles while 20 in-range plots arrive (DEPTH=16) → overflow=1. On grant, exactly the first 16 pixels are written, in order.
- FIFO full, then a push with fb_grant=1 in the same cycle → no overflow, count stays 16, and all 17 pixels are eventually written.
- Assert rst with 8 pixels buffered → fb_we=0 immediately; after release busy=0, no writes, overflow=0.
- overflow=1, then clr_flags coincident with another drop → overflow stays 1. clr_flags alone on the next cycle → 0.
